// File: rtl/raycast_pkg.sv
// Shared constants and state encoding for the ray angle sequencer.
// Angles are integer degrees plus thousandths of a degree.
package raycast_pkg;

  localparam int DEG_FULL  = 360;
  localparam int FRAC_FULL = 1000;

  localparam int DEF_HALF_FOV_DEG = 30;
  localparam int DEF_STEP_FRAC    = 375;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/angle_step_add.sv
// Adds a fixed fractional step to a degree/thousandths angle.
// Carries fraction overflow into degrees and wraps 360 back to 0.
module angle_step_add
  import raycast_pkg::*;
#(
  parameter int STEP = DEF_STEP_FRAC
) (
  input  logic [8:0] ang_int,
  input  logic [9:0] ang_frac,
  output logic [8:0] next_int,
  output logic [9:0] next_frac
);

  logic [10:0] frac_sum;
  logic [9:0]  int_sum;
  logic        carry;

  always_comb begin
    frac_sum = {1'b0, ang_frac} + 11'(STEP);
    carry    = frac_sum >= 11'(FRAC_FULL);
    if (carry)
      next_frac = 10'(frac_sum - 11'(FRAC_FULL));
    else
      next_frac = frac_sum[9:0];
    int_sum = {1'b0, ang_int} + {9'd0, carry};
    if (int_sum >= 10'(DEG_FULL))
      next_int = 9'(int_sum - 10'(DEG_FULL));
    else
      next_int = int_sum[8:0];
  end

endmodule

// File: rtl/ray_angle_sequencer.sv
// Walks one frame of screen columns, issuing a ray angle per column
// over a valid/ready handshake, starting half a FOV left of the player.
module ray_angle_sequencer
  import raycast_pkg::*;
#(
  parameter int H_RES        = 160,
  parameter int HALF_FOV_DEG = DEF_HALF_FOV_DEG,
  parameter int STEP_FRAC    = DEF_STEP_FRAC
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [8:0] player_angle_int,
  input  logic [9:0] player_angle_frac,
  input  logic       col_ready,
  output logic       col_valid,
  output logic [7:0] col_index,
  output logic [8:0] ray_angle_int,
  output logic [9:0] ray_angle_frac,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [7:0] LAST_COL = 8'(H_RES - 1);
  localparam logic [9:0] FOV      = 10'(HALF_FOV_DEG);

  state_t     state;
  logic [8:0] cap_int;
  logic [9:0] cap_frac;
  logic [9:0] cap_wide;
  logic [8:0] base_int;
  logic [8:0] step_int;
  logic [9:0] step_frac;

  always_comb begin
    cap_wide = {1'b0, cap_int};
    if (cap_wide >= FOV)
      base_int = 9'(cap_wide - FOV);
    else
      base_int = 9'(cap_wide + 10'(DEG_FULL) - FOV);
  end

  angle_step_add #(
    .STEP(STEP_FRAC)
  ) u_step (
    .ang_int  (ray_angle_int),
    .ang_frac (ray_angle_frac),
    .next_int (step_int),
    .next_frac(step_frac)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      cap_int        <= '0;
      cap_frac       <= '0;
      col_valid      <= 1'b0;
      col_index      <= '0;
      ray_angle_int  <= '0;
      ray_angle_frac <= '0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cap_int  <= player_angle_int;
            cap_frac <= player_angle_frac;
            busy     <= 1'b1;
            state    <= INIT;
          end
        end
        INIT: begin
          col_index      <= '0;
          ray_angle_int  <= base_int;
          ray_angle_frac <= cap_frac;
          col_valid      <= 1'b1;
          state          <= ISSUE;
        end
        ISSUE: begin
          if (col_ready) begin
            if (col_index == LAST_COL) begin
              col_valid  <= 1'b0;
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              col_index      <= col_index + 8'd1;
              ray_angle_int  <= step_int;
              ray_angle_frac <= step_frac;
            end
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ray_angle_sequencer.sv
// Randomised and directed frame checks for ray_angle_sequencer
// against an angle model in whole thousandths of a degree.
module tb_ray_angle_sequencer;

  localparam int H_RES = 160;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [8:0] player_angle_int;
  logic [9:0] player_angle_frac;
  logic       col_ready;
  logic       col_valid;
  logic [7:0] col_index;
  logic [8:0] ray_angle_int;
  logic [9:0] ray_angle_frac;
  logic       busy;
  logic       frame_done;

  int checks = 0;
  int errors = 0;
  int got_int[H_RES];
  int got_frac[H_RES];
  int frame_cycles;

  ray_angle_sequencer #(
    .H_RES(H_RES),
    .HALF_FOV_DEG(30),
    .STEP_FRAC(375)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .start            (start),
    .player_angle_int (player_angle_int),
    .player_angle_frac(player_angle_frac),
    .col_ready        (col_ready),
    .col_valid        (col_valid),
    .col_index        (col_index),
    .ray_angle_int    (ray_angle_int),
    .ray_angle_frac   (ray_angle_frac),
    .busy             (busy),
    .frame_done       (frame_done)
  );

  always #5 clk = ~clk;

  // Ray angle of column col, in thousandths of a degree, 0..359999
  function automatic int model_mdeg(input int pint, input int pfrac,
                                    input int col);
    int base;
    base = (pint * 1000 + pfrac - 30000 + 360000) % 360000;
    return (base + col * 375) % 360000;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int pint, input int pfrac,
                           input int stall_col, input int stall_len,
                           input bit rand_ready, input int start_col);
    int k;
    int cyc;
    int stalled;
    int exp_m;
    bit seen_valid;
    k = 0;
    cyc = 0;
    stalled = 0;
    seen_valid = 0;
    player_angle_int = 9'(pint);
    player_angle_frac = 10'(pfrac);
    start = 1'b1;
    col_ready = 1'b0;
    tick();
    start = 1'b0;
    player_angle_int = 9'($urandom_range(0, 359));
    player_angle_frac = 10'($urandom_range(0, 999));
    checks++;
    if (col_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL init_phase valid=%b busy=%b expected 0 1",
               col_valid, busy);
    end
    cyc = 1;
    while (k < H_RES && cyc < 2000) begin
      if (k == stall_col && stalled < stall_len) begin
        col_ready = 1'b0;
        if (col_valid) stalled++;
      end else if (rand_ready) begin
        col_ready = ($urandom_range(0, 3) != 0);
      end else begin
        col_ready = 1'b1;
      end
      checks++;
      if (frame_done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL in_frame k=%0d done=%b busy=%b expected 0 1",
                 k, frame_done, busy);
      end
      if (col_valid === 1'b1) begin
        exp_m = model_mdeg(pint, pfrac, k);
        checks++;
        if (int'(col_index) !== k ||
            int'(ray_angle_int) !== exp_m / 1000 ||
            int'(ray_angle_frac) !== exp_m % 1000) begin
          errors++;
          $display("FAIL column got idx %0d ang %0d.%0d expected %0d %0d.%0d",
                   col_index, ray_angle_int, ray_angle_frac,
                   k, exp_m / 1000, exp_m % 1000);
        end
        got_int[k] = int'(ray_angle_int);
        got_frac[k] = int'(ray_angle_frac);
        seen_valid = 1;
        if (k == start_col) begin
          start = 1'b1;
          player_angle_int = 9'($urandom_range(0, 359));
        end
        if (col_ready) k++;
      end else if (seen_valid) begin
        checks++;
        errors++;
        $display("FAIL valid_dropped k=%0d got 0 expected 1", k);
      end
      tick();
      start = 1'b0;
      cyc++;
    end
    frame_cycles = cyc;
    col_ready = 1'b0;
    checks++;
    if (cyc >= 2000) begin
      errors++;
      $display("FAIL frame_timeout got %0d columns expected %0d", k, H_RES);
    end
    checks++;
    if (frame_done !== 1'b1 || col_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse got done=%b valid=%b busy=%b expected 1 0 1",
               frame_done, col_valid, busy);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || col_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_done got done=%b busy=%b valid=%b expected 0 0 0",
               frame_done, busy, col_valid);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    start = 1'b0;
    col_ready = 1'b0;
    player_angle_int = 9'd45;
    player_angle_frac = 10'd0;
    tick();
    tick();
    checks++;
    if ({col_valid, busy, frame_done} !== 3'b000 ||
        col_index !== 8'd0 || ray_angle_int !== 9'd0 ||
        ray_angle_frac !== 10'd0) begin
      errors++;
      $display("FAIL reset_state got v%b b%b d%b i%0d a%0d.%0d expected all 0",
               col_valid, busy, frame_done, col_index,
               ray_angle_int, ray_angle_frac);
    end
    resetn = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || col_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start got busy=%b valid=%b expected 0 0",
               busy, col_valid);
    end
  endtask

  task automatic test_player_90;
    run_frame(90, 0, -1, 0, 1'b0, -1);
    checks++;
    if (frame_cycles !== H_RES + 2) begin
      errors++;
      $display("FAIL b2b_cycles got %0d expected %0d", frame_cycles, H_RES + 2);
    end
    checks++;
    if (got_int[0] !== 60 || got_frac[0] !== 0 ||
        got_int[1] !== 60 || got_frac[1] !== 375 ||
        got_int[159] !== 119 || got_frac[159] !== 625) begin
      errors++;
      $display("FAIL p90_points got %0d.%0d %0d.%0d %0d.%0d expected 60.0 60.375 119.625",
               got_int[0], got_frac[0], got_int[1], got_frac[1],
               got_int[159], got_frac[159]);
    end
  endtask

  task automatic test_wrap;
    run_frame(10, 0, -1, 0, 1'b0, -1);
    checks++;
    if (got_int[0] !== 340 || got_frac[0] !== 0 ||
        got_int[53] !== 359 || got_frac[53] !== 875 ||
        got_int[54] !== 0 || got_frac[54] !== 250) begin
      errors++;
      $display("FAIL wrap_points got %0d.%0d %0d.%0d %0d.%0d expected 340.0 359.875 0.250",
               got_int[0], got_frac[0], got_int[53], got_frac[53],
               got_int[54], got_frac[54]);
    end
  endtask

  task automatic test_frac_carry;
    run_frame(0, 500, -1, 0, 1'b0, -1);
    checks++;
    if (got_int[0] !== 330 || got_frac[0] !== 500 ||
        got_int[1] !== 330 || got_frac[1] !== 875 ||
        got_int[2] !== 331 || got_frac[2] !== 250) begin
      errors++;
      $display("FAIL carry_points got %0d.%0d %0d.%0d %0d.%0d expected 330.500 330.875 331.250",
               got_int[0], got_frac[0], got_int[1], got_frac[1],
               got_int[2], got_frac[2]);
    end
  endtask

  task automatic test_stall;
    run_frame(45, 123, 7, 5, 1'b0, -1);
    checks++;
    if (frame_cycles !== H_RES + 7) begin
      errors++;
      $display("FAIL stall_cycles got %0d expected %0d", frame_cycles, H_RES + 7);
    end
  endtask

  task automatic test_start_ignored;
    run_frame(200, 999, -1, 0, 1'b0, 40);
    checks++;
    if (frame_cycles !== H_RES + 2) begin
      errors++;
      $display("FAIL restart_cycles got %0d expected %0d", frame_cycles, H_RES + 2);
    end
  endtask

  task automatic test_mid_reset;
    int cyc;
    bit reached;
    cyc = 0;
    reached = 0;
    player_angle_int = 9'd120;
    player_angle_frac = 10'd0;
    start = 1'b1;
    col_ready = 1'b1;
    tick();
    start = 1'b0;
    while (!reached && cyc < 400) begin
      if (col_valid === 1'b1 && col_index === 8'd80) reached = 1;
      else begin
        tick();
        cyc++;
      end
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL reach_col80 got idx %0d expected 80", col_index);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({col_valid, busy, frame_done} !== 3'b000 ||
        col_index !== 8'd0 || ray_angle_int !== 9'd0 ||
        ray_angle_frac !== 10'd0) begin
      errors++;
      $display("FAIL async_reset got v%b b%b d%b i%0d a%0d.%0d expected all 0",
               col_valid, busy, frame_done, col_index,
               ray_angle_int, ray_angle_frac);
    end
    tick();
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (col_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle got v%b b%b d%b expected 0 0 0",
                 col_valid, busy, frame_done);
      end
    end
    run_frame(120, 0, -1, 0, 1'b0, -1);
    checks++;
    if (got_int[0] !== 90 || got_frac[0] !== 0) begin
      errors++;
      $display("FAIL restart_col0 got %0d.%0d expected 90.0",
               got_int[0], got_frac[0]);
    end
  endtask

  task automatic test_random;
    for (int f = 0; f < 4; f++) begin
      run_frame($urandom_range(0, 359), $urandom_range(0, 999),
                $urandom_range(0, H_RES - 1), $urandom_range(0, 6),
                1'b1, -1);
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_player_90();
    test_wrap();
    test_frac_carry();
    test_stall();
    test_start_ignored();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
